// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   XLEN             : address / instruction width
//   NOP_INSTR        : addi x0,x0,0, presented whenever IF/ID holds a bubble
//   RESET_PC_DEFAULT : first fetch address after reset
//   fetch_entry_t    : {valid, instr, pc} tuple used by the IF/ID register and the skid buffer
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Bubble entry; the pc field is carried along only so it does not toggle needlessly.
  function automatic fetch_entry_t bubble(input logic [XLEN-1:0] pc);
    fetch_entry_t e;
    e.valid = 1'b0;
    e.instr = NOP_INSTR;
    e.pc    = pc;
    return e;
  endfunction
endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer holding a fetched word that arrived while IF/ID was stalled.
//   clk, rst : clock, synchronous active-high reset
//   flush    : drop the held entry (redirect); wins over wr_en and rd_en
//   wr_en    : capture wr_data
//   rd_en    : consumer takes the held entry this cycle
//   valid    : an entry is held
//   rd_data  : held entry
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         wr_en,
  input  fetch_entry_t wr_data,
  input  logic         rd_en,
  output logic         valid,
  output fetch_entry_t rd_data
);
  logic         r_valid;
  fetch_entry_t r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= bubble('0);
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (wr_en) begin
      r_valid <= 1'b1;
      r_data  <= wr_data;
    end else if (rd_en) begin
      r_valid <= 1'b0;
    end
  end

  assign valid   = r_valid;
  assign rd_data = r_data;
endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, request issue to a 1-cycle synchronous
// instruction memory, IF/ID register and a one-entry skid buffer for stalls.
//   clk, rst        : clock, synchronous active-high reset
//   stall_i         : hold IF/ID, issue no new sequential fetch
//   redirect_i      : flush and restart at redirect_pc_i (bits [1:0] ignored)
//   imem_req_o/addr : fetch request and byte address
//   imem_rdata_i    : read data, one cycle after the request
//   valid_o/instr_o/pc_o/pc_plus4_o : IF/ID contents toward the decoders
module fetch_stage #(
  parameter int                  XLEN     = fetch_pkg::XLEN,
  parameter logic [XLEN-1:0]     RESET_PC = fetch_pkg::RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus4_o
);
  import fetch_pkg::*;

  localparam logic [XLEN-1:0] W4 = XLEN'(4);

  logic            r_inflight;
  logic [XLEN-1:0] r_pc, r_inflight_pc;
  fetch_entry_t    r_ifid;

  logic            w_issue, w_skid_valid, w_skid_wr, w_skid_rd;
  logic [XLEN-1:0] w_addr;
  fetch_entry_t    w_resp, w_skid_data;

  // A redirect always issues its target, even under stall, so it starts as early as possible.
  assign w_issue = !rst && (redirect_i || !stall_i);
  assign w_addr  = redirect_i ? (redirect_pc_i & ~XLEN'(3)) : r_pc;

  assign w_resp = '{valid: 1'b1, instr: imem_rdata_i, pc: r_inflight_pc};

  // Under stall nothing new issues, so only the single in-flight word needs parking.
  assign w_skid_wr = !redirect_i && stall_i && r_inflight;
  assign w_skid_rd = !redirect_i && !stall_i;

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .rst     (rst),
    .flush   (redirect_i),
    .wr_en   (w_skid_wr),
    .wr_data (w_resp),
    .rd_en   (w_skid_rd),
    .valid   (w_skid_valid),
    .rd_data (w_skid_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_ifid        <= bubble('0);
    end else begin
      if (w_issue) begin
        r_pc          <= w_addr + W4;
        r_inflight    <= 1'b1;
        r_inflight_pc <= w_addr;
      end else begin
        r_inflight    <= 1'b0;
      end

      // Redirect discards IF/ID and this cycle's response; skid drains before
      // the response so program order survives a stall release.
      if (redirect_i)        r_ifid <= bubble(r_ifid.pc);
      else if (!stall_i) begin
        if (w_skid_valid)    r_ifid <= w_skid_data;
        else if (r_inflight) r_ifid <= w_resp;
        else                 r_ifid <= bubble(r_ifid.pc);
      end
    end
  end

  assign imem_req_o  = w_issue;
  assign imem_addr_o = w_addr;
  assign valid_o     = r_ifid.valid;
  assign instr_o     = r_ifid.instr;
  assign pc_o        = r_ifid.pc;
  assign pc_plus4_o  = r_ifid.pc + W4;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stall_i, redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic        valid_o;
  logic [31:0] instr_o, pc_o, pc_plus4_o;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rdata_i(imem_rdata_i), .valid_o(valid_o), .instr_o(instr_o),
    .pc_o(pc_o), .pc_plus4_o(pc_plus4_o)
  );

  always #5 clk = ~clk;

  // ROM[i] = i*4 + 1, i.e. the word at byte address a is a+1. Garbage when not requested.
  always @(posedge clk) imem_rdata_i <= imem_req_o ? imem_addr_o + 32'd1 : 32'hDEAD_BEEF;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    tick(); tick(); #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", imem_req_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", valid_o); end
    checks++; if (instr_o !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h exp 00000013", instr_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc_o); end
    checks++; if (pc_plus4_o !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %h exp 4", pc_plus4_o); end
  endtask

  // Cycles 0..4 after reset release.
  task automatic test_sequential();
    tick(); rst = 1'b0; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL seq_c0_issue: got req=%b addr=%h exp 1/0", imem_req_o, imem_addr_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL seq_c1: got valid=%b addr=%h exp 0/4", valid_o, imem_addr_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h1 || pc_plus4_o !== 32'h4) begin errors++; $display("FAIL seq_c2: got v=%b pc=%h ins=%h p4=%h exp 1/0/1/4", valid_o, pc_o, instr_o, pc_plus4_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== 32'h5 || pc_plus4_o !== 32'h8) begin errors++; $display("FAIL seq_c3: got v=%b pc=%h ins=%h p4=%h exp 1/4/5/8", valid_o, pc_o, instr_o, pc_plus4_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h8 || instr_o !== 32'h9 || pc_plus4_o !== 32'hC) begin errors++; $display("FAIL seq_c4: got v=%b pc=%h ins=%h p4=%h exp 1/8/9/c", valid_o, pc_o, instr_o, pc_plus4_o); end
  endtask

  // Stall in cycles 5..7; word for 0x10 is in flight in cycle 5 and must come out of the skid.
  task automatic test_stall();
    tick(); stall_i = 1'b1; #1;
    checks++; if (imem_req_o !== 1'b0 || pc_o !== 32'hC || instr_o !== 32'hD) begin errors++; $display("FAIL stall_c5: got req=%b pc=%h ins=%h exp 0/c/d", imem_req_o, pc_o, instr_o); end
    tick(); #1;
    checks++; if (imem_req_o !== 1'b0 || pc_o !== 32'hC) begin errors++; $display("FAIL stall_c6: got req=%b pc=%h exp 0/c", imem_req_o, pc_o); end
    tick(); #1;
    checks++; if (imem_req_o !== 1'b0 || pc_o !== 32'hC || valid_o !== 1'b1) begin errors++; $display("FAIL stall_c7: got req=%b pc=%h v=%b exp 0/c/1", imem_req_o, pc_o, valid_o); end
    tick(); stall_i = 1'b0; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h14 || pc_o !== 32'hC) begin errors++; $display("FAIL stall_release: got req=%b addr=%h pc=%h exp 1/14/c", imem_req_o, imem_addr_o, pc_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h10 || instr_o !== 32'h11) begin errors++; $display("FAIL stall_skid_out: got v=%b pc=%h ins=%h exp 1/10/11", valid_o, pc_o, instr_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h14 || instr_o !== 32'h15) begin errors++; $display("FAIL stall_next: got v=%b pc=%h ins=%h exp 1/14/15", valid_o, pc_o, instr_o); end
  endtask

  // Redirect in cycle R to target; exp is the word-aligned fetch address.
  task automatic test_redirect(input string tag, input logic [31:0] target, input logic [31:0] exp);
    tick(); redirect_i = 1'b1; redirect_pc_i = target; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== exp) begin errors++; $display("FAIL %s_issue: got req=%b addr=%h exp 1/%h", tag, imem_req_o, imem_addr_o, exp); end
    tick(); redirect_i = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13 || imem_addr_o !== exp + 32'd4) begin errors++; $display("FAIL %s_r1: got v=%b ins=%h addr=%h exp 0/13/%h", tag, valid_o, instr_o, imem_addr_o, exp + 32'd4); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== exp || instr_o !== exp + 32'd1 || pc_plus4_o !== exp + 32'd4) begin errors++; $display("FAIL %s_r2: got v=%b pc=%h ins=%h p4=%h exp 1/%h/%h/%h", tag, valid_o, pc_o, instr_o, pc_plus4_o, exp, exp + 32'd1, exp + 32'd4); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== exp + 32'd4 || instr_o !== exp + 32'd5) begin errors++; $display("FAIL %s_r3: got v=%b pc=%h ins=%h exp 1/%h/%h", tag, valid_o, pc_o, instr_o, exp + 32'd4, exp + 32'd5); end
  endtask

  // Stall fills the skid, then a redirect arrives while still stalled.
  task automatic test_redirect_in_stall();
    tick(); stall_i = 1'b1; #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rs_stall_req: got %b exp 0", imem_req_o); end
    tick(); redirect_i = 1'b1; redirect_pc_i = 32'h300; #1;
    checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin errors++; $display("FAIL rs_issue: got req=%b addr=%h exp 1/300", imem_req_o, imem_addr_o); end
    tick(); redirect_i = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || imem_req_o !== 1'b0) begin errors++; $display("FAIL rs_flushed: got v=%b req=%b exp 0/0", valid_o, imem_req_o); end
    tick(); stall_i = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || imem_addr_o !== 32'h304) begin errors++; $display("FAIL rs_release: got v=%b addr=%h exp 0/304", valid_o, imem_addr_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h300 || instr_o !== 32'h301) begin errors++; $display("FAIL rs_target: got v=%b pc=%h ins=%h exp 1/300/301", valid_o, pc_o, instr_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h304 || instr_o !== 32'h305) begin errors++; $display("FAIL rs_next: got v=%b pc=%h ins=%h exp 1/304/305", valid_o, pc_o, instr_o); end
  endtask

  // Reset while the skid holds a word: nothing stale may emerge afterwards.
  task automatic test_reset_mid();
    tick(); stall_i = 1'b1;
    tick(); stall_i = 1'b0; rst = 1'b1; #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rm_req: got %b exp 0", imem_req_o); end
    tick(); rst = 1'b0; #1;
    checks++; if (valid_o !== 1'b0 || pc_o !== 32'h0 || pc_plus4_o !== 32'h4 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL rm_c0: got v=%b pc=%h p4=%h req=%b addr=%h exp 0/0/4/1/0", valid_o, pc_o, pc_plus4_o, imem_req_o, imem_addr_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b0 || instr_o !== 32'h13) begin errors++; $display("FAIL rm_c1: got v=%b ins=%h exp 0/13", valid_o, instr_o); end
    tick(); #1;
    checks++; if (valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== 32'h1) begin errors++; $display("FAIL rm_c2: got v=%b pc=%h ins=%h exp 1/0/1", valid_o, pc_o, instr_o); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect("redir", 32'h100, 32'h100);
    test_redirect("unalign", 32'h203, 32'h200);
    test_redirect_in_stall();
    test_redirect("wrap", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
